// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_if
// Purpose  : Handshake bundle between fetch, the instruction queue and decode.
//            The master side is the environment (fetch stage driving the
//            input half, decode driving out_ready); the slave side is the
//            queue itself.
// Signals  : in_valid/in_ready/in_pc/in_instr   - fetch -> queue
//            out_valid/out_ready/out_pc/out_instr/out_misaligned - queue -> decode
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misaligned;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_misaligned
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_misaligned
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Circular FIFO of {pc, instr} pairs between fetch and decode.
//            in_ready doubles as the fetch PC-advance enable; flush drops all
//            buffered wrong-path entries on a redirect.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            flush          - discard every entry at this edge
//            bus (slave)    - fetch/decode handshake bundle
//            count          - occupied entries, 0..DEPTH
//            flush_drops    - saturating total of entries discarded by flush
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  fetch_queue_if.slave          bus,
  output logic [CNT_W-1:0]      count,
  output logic [15:0]           flush_drops
);

  localparam int              c_ptr_w = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  logic [63:0]        r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wp;
  logic [c_ptr_w-1:0] r_rp;
  logic [CNT_W-1:0]   r_count;
  logic [15:0]        r_drops;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [16:0]        w_drops_sum;
  logic [63:0]        w_head;

  // Full/empty come only from registered occupancy, so a pop never
  // combinationally opens room for a push in the same cycle.
  assign w_in_ready  = (r_count != c_full);
  assign w_out_valid = (r_count != '0);

  assign w_push = bus.in_valid && w_in_ready && !flush;
  assign w_pop  = w_out_valid && bus.out_ready && !flush;

  // One extra bit catches the carry so the drop counter can clamp.
  assign w_drops_sum = {1'b0, r_drops} + 17'(r_count);

  assign w_head = w_out_valid ? r_mem[r_rp] : 64'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_drops <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_drops <= w_drops_sum[16] ? 16'hFFFF : w_drops_sum[15:0];
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {bus.in_pc, bus.in_instr};
        r_wp        <= r_wp + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_pc         = w_head[63:32];
  assign bus.out_instr      = w_head[31:0];
  // Misaligned PCs pass through untouched; this is only a flag for decode.
  assign bus.out_misaligned = w_out_valid && (w_head[33:32] != 2'b00);
  assign count              = r_count;
  assign flush_drops        = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue. A DEPTH=2 instance is
//            compared every cycle against a queue-based scoreboard; a
//            DEPTH=64 instance drives the flush_drops counter into saturation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        flush_big;
  logic [1:0]  count;
  logic [15:0] flush_drops;
  logic [6:0]  count_big;
  logic [15:0] drops_big;

  fetch_queue_if ifc ();
  fetch_queue_if ifc_big ();

  fetch_queue #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (ifc),
    .count       (count),
    .flush_drops (flush_drops)
  );

  fetch_queue #(.DEPTH(64)) dut_big (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush_big),
    .bus         (ifc_big),
    .count       (count_big),
    .flush_drops (drops_big)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  logic [63:0] sb [$];
  int          drops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are already driven; compare mid-cycle, then advance one edge and
  // update the reference model from the inputs that edge sampled.
  task automatic tick();
    logic        push;
    logic        pop;
    logic [63:0] head;
    int          sz;
    #2;
    sz   = sb.size();
    head = (sz != 0) ? sb[0] : 64'h0;
    check("count",          64'(count),              64'(sz));
    check("in_ready",       64'(ifc.in_ready),       64'(sz != 2));
    check("out_valid",      64'(ifc.out_valid),      64'(sz != 0));
    check("out_pc",         64'(ifc.out_pc),         64'(head[63:32]));
    check("out_instr",      64'(ifc.out_instr),      64'(head[31:0]));
    check("out_misaligned", 64'(ifc.out_misaligned), 64'((sz != 0) && (head[33:32] != 2'b00)));
    check("flush_drops",    64'(flush_drops),        64'(drops));
    push = ifc.in_valid && (sz != 2) && !flush;
    pop  = (sz != 0) && ifc.out_ready && !flush;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      drops = 0;
    end else if (flush) begin
      drops = (drops + sz > 65535) ? 65535 : drops + sz;
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back({ifc.in_pc, ifc.in_instr});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    ifc.in_valid  = v;
    ifc.in_pc     = pc;
    ifc.in_instr  = ins;
    ifc.out_ready = ordy;
    flush         = fl;
  endtask

  initial begin
    int exp_big;
    vectors     = 0;
    miscompares = 0;
    drops       = 0;
    rst         = 1'b1;
    flush_big   = 1'b0;
    ifc_big.in_valid  = 1'b0;
    ifc_big.in_pc     = 32'h0;
    ifc_big.in_instr  = 32'h0;
    ifc_big.out_ready = 1'b0;
    drive(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(posedge clk); #1;
    sb.delete();

    // Reset held with in_valid asserted.
    tick();
    tick();

    // Streaming with decode always ready.
    rst = 1'b0;
    drive(1'b1, 32'h0, 32'h0000_0013, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h4, 32'h0010_0093, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h8, 32'h0020_0113, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0,         1'b1, 1'b0); tick();
    tick();

    // Fill and hold, then drain; 0x18 waits until there is room.
    drive(1'b1, 32'h10, 32'h1111_0010, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h14, 32'h1111_0014, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h18, 32'h1111_0018, 1'b0, 1'b0); tick();
    tick();
    ifc.out_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    tick();

    // Flush with a push and pop presented in the same cycle.
    drive(1'b1, 32'hA0, 32'h2222_00A0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hA4, 32'h2222_00A4, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h40, 32'h2222_0040, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h80, 32'h2222_0080, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0,  32'h0,         1'b0, 1'b0); tick();
    tick();
    ifc.out_ready = 1'b1;
    tick();
    // Flush while empty must not move flush_drops.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    flush = 1'b0;
    tick();

    // Pointer wrap, then a misaligned PC held at the head.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 32'h3333_0000 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 32'h22, 32'h4444_0022, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0,  32'h0,         1'b0, 1'b0); tick();
    tick();
    ifc.out_ready = 1'b1;
    tick();
    tick();

    // Random traffic with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();

    // Saturation of flush_drops on the deep instance.
    flush_big = 1'b1;
    @(posedge clk); #1;
    flush_big = 1'b0;
    check("big_empty_flush", 64'(drops_big), 64'h0);
    exp_big = 0;
    for (int r = 0; r < 1025; r++) begin
      ifc_big.in_valid = 1'b1;
      for (int k = 0; k < 64; k++) begin
        ifc_big.in_pc    = 32'(k * 4);
        ifc_big.in_instr = 32'(r);
        @(posedge clk); #1;
      end
      if (r == 0) begin
        check("big_count_full", 64'(count_big),        64'd64);
        check("big_in_ready",   64'(ifc_big.in_ready), 64'd0);
        check("big_head_pc",    64'(ifc_big.out_pc),   64'h0);
      end
      flush_big = 1'b1;
      @(posedge clk); #1;
      flush_big = 1'b0;
      exp_big = (exp_big + 64 > 65535) ? 65535 : exp_big + 64;
      if (r == 0 || r >= 1021) begin
        check("big_drops", 64'(drops_big), 64'(exp_big));
        check("big_count_after_flush", 64'(count_big), 64'h0);
      end
    end
    ifc_big.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
